// File: rtl/ext_display_if.sv
// Bus between the pipeline's external-write path and the seven-segment display controller.
// Carries the write strobe/target/data, the acknowledge pulse, the readback port and the
// display drive lines. The pipeline side uses the master modport; the controller uses slave.
interface ext_display_if;
  logic        ex_write;
  logic [1:0]  ex_ano;
  logic [31:0] ex_data;
  logic        ex_ack;
  logic [1:0]  rd_sel;
  logic [7:0]  rd_data;
  logic [3:0]  an;
  logic [7:0]  seg;

  modport master (
    output ex_write, ex_ano, ex_data, rd_sel,
    input  ex_ack, rd_data, an, seg
  );

  modport slave (
    input  ex_write, ex_ano, ex_data, rd_sel,
    output ex_ack, rd_data, an, seg
  );
endinterface

// File: rtl/ext_display_ctrl.sv
// External display controller: latches pipeline writes into four digit registers and
// time-multiplexes them onto a 4-digit common-anode seven-segment display (active-low
// anodes and segments). Each digit owns CLK_DIV cycles of the scan; the last cycle of
// every slot blanks the display so adjacent digits never ghost into each other.
// Optional build macro HEX_DECODE_EN: when defined, writes store a hex-to-segment decode
// of ex_data[3:0] with dp driven by ex_data[4]; otherwise ex_data[7:0] is stored raw.
module ext_display_ctrl #(
  parameter int CLK_DIV = 100000,
  parameter int SCAN_W  = 17
) (
  input logic         clk,
  input logic         reset,
  ext_display_if.slave bus
);

  localparam logic [SCAN_W-1:0] LAST_CNT = SCAN_W'(CLK_DIV - 1);

  logic [7:0]        dig [4];
  logic [SCAN_W-1:0] divCnt;
  logic [1:0]        scanIdx;
  logic [7:0]        storeVal;
  logic              deadTime;

  assign deadTime = (divCnt == LAST_CNT);

`ifdef HEX_DECODE_EN
  logic unusedDataBits;
  assign unusedDataBits = ^bus.ex_data[31:5];

  // Hex nibble to active-low gfedcba pattern, with dp lit when ex_data[4] is set
  always_comb begin
    storeVal = 8'hFF;
    case (bus.ex_data[3:0])
      4'h0: storeVal[6:0] = 7'h40;
      4'h1: storeVal[6:0] = 7'h79;
      4'h2: storeVal[6:0] = 7'h24;
      4'h3: storeVal[6:0] = 7'h30;
      4'h4: storeVal[6:0] = 7'h19;
      4'h5: storeVal[6:0] = 7'h12;
      4'h6: storeVal[6:0] = 7'h02;
      4'h7: storeVal[6:0] = 7'h78;
      4'h8: storeVal[6:0] = 7'h00;
      4'h9: storeVal[6:0] = 7'h10;
      4'hA: storeVal[6:0] = 7'h08;
      4'hB: storeVal[6:0] = 7'h03;
      4'hC: storeVal[6:0] = 7'h46;
      4'hD: storeVal[6:0] = 7'h21;
      4'hE: storeVal[6:0] = 7'h06;
      default: storeVal[6:0] = 7'h0E;
    endcase
    storeVal[7] = ~bus.ex_data[4];
  end
`else
  logic unusedDataBits;
  assign unusedDataBits = ^bus.ex_data[31:8];
  assign storeVal = bus.ex_data[7:0];
`endif

  // Digit registers and write acknowledge; reset drops any write issued in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) dig[i] <= 8'hFF;
      bus.ex_ack <= 1'b0;
    end else begin
      bus.ex_ack <= bus.ex_write;
      if (bus.ex_write) dig[bus.ex_ano] <= storeVal;
    end
  end

  // Slot divider and digit scan pointer, advancing to the next digit on divider wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt  <= '0;
      scanIdx <= 2'd0;
    end else if (deadTime) begin
      divCnt  <= '0;
      scanIdx <= scanIdx + 2'd1;
    end else begin
      divCnt  <= divCnt + 1'b1;
    end
  end

  // Registered display drive: blank during the dead-time cycle, otherwise light the scanned digit
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.an  <= 4'hF;
      bus.seg <= 8'hFF;
    end else if (deadTime) begin
      bus.an  <= 4'hF;
      bus.seg <= 8'hFF;
    end else begin
      bus.an  <= ~(4'b0001 << scanIdx);
      bus.seg <= dig[scanIdx];
    end
  end

  assign bus.rd_data = dig[bus.rd_sel];

endmodule

// File: tb/tb_ext_display_ctrl.sv
// Self-checking bench for ext_display_ctrl with CLK_DIV = 4. A cycle model predicts
// an/seg/ex_ack for each edge; predictions are queued when stimulus is driven and popped
// once the edge has happened. Each scenario task also makes its own directed checks.
module tb_ext_display_ctrl;

  localparam int CLK_DIV = 4;
  localparam int SCAN_W  = 3;

  localparam logic [7:0] HEX_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic       ack;
  } expT;

  logic clk;
  logic reset;
  ext_display_if bus ();

  ext_display_ctrl #(.CLK_DIV(CLK_DIV), .SCAN_W(SCAN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  expT        expQ [$];
  logic [7:0] mDig [4];
  int         mCnt;
  int         mIdx;

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] storedOf(input logic [7:0] d);
`ifdef HEX_DECODE_EN
    logic [7:0] v;
    v = HEX_TAB[d[3:0]];
    v[7] = ~d[4];
    return v;
`else
    return d;
`endif
  endfunction

  // One clock: drive inputs, queue the predicted outputs, advance the model, then compare
  task automatic stepCycle(input logic rst, input logic wr, input logic [1:0] ano,
                           input logic [7:0] data);
    expT e;
    expT got;
    reset        = rst;
    bus.ex_write = wr;
    bus.ex_ano   = ano;
    bus.ex_data  = {24'hA5C35A, data};
    if (rst) begin
      e.an = 4'hF; e.seg = 8'hFF; e.ack = 1'b0;
      for (int i = 0; i < 4; i++) mDig[i] = 8'hFF;
      mCnt = 0;
      mIdx = 0;
    end else begin
      e.ack = wr;
      if (mCnt == CLK_DIV - 1) begin
        e.an = 4'hF; e.seg = 8'hFF;
      end else begin
        e.an  = 4'hF;
        e.an[mIdx] = 1'b0;
        e.seg = mDig[mIdx];
      end
      if (wr) mDig[ano] = storedOf(data);
      mCnt = mCnt + 1;
      if (mCnt == CLK_DIV) begin
        mCnt = 0;
        mIdx = (mIdx + 1) % 4;
      end
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    got.an = bus.an; got.seg = bus.seg; got.ack = bus.ex_ack;
    total++;
    if (got.an !== e.an) begin
      bad++; $display("[TB] FAIL sb_an: got %h expected %h", got.an, e.an);
    end
    total++;
    if (got.seg !== e.seg) begin
      bad++; $display("[TB] FAIL sb_seg: got %h expected %h", got.seg, e.seg);
    end
    total++;
    if (got.ack !== e.ack) begin
      bad++; $display("[TB] FAIL sb_ack: got %b expected %b", got.ack, e.ack);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) stepCycle(1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic test_reset;
    logic [3:0] anTab [4] = '{4'hE, 4'hE, 4'hE, 4'hF};
    for (int i = 0; i < 3; i++) stepCycle(1'b1, 1'b0, 2'd0, 8'h00);
    total++;
    if (bus.an !== 4'hF || bus.seg !== 8'hFF || bus.ex_ack !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got an=%h seg=%h ack=%b expected an=f seg=ff ack=0",
               bus.an, bus.seg, bus.ex_ack);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1);
      total++;
      if (bus.an !== anTab[i]) begin
        bad++; $display("[TB] FAIL post_reset_an[%0d]: got %h expected %h", i, bus.an, anTab[i]);
      end
      total++;
      if (bus.seg !== 8'hFF) begin
        bad++; $display("[TB] FAIL post_reset_seg[%0d]: got %h expected ff", i, bus.seg);
      end
    end
  endtask

  task automatic test_scan_order;
    logic [3:0] scanTab [17] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                                 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'hE};
    stepCycle(1'b1, 1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 17; i++) begin
      idle(1);
      total++;
      if (bus.an !== scanTab[i]) begin
        bad++; $display("[TB] FAIL scan_an[%0d]: got %h expected %h", i, bus.an, scanTab[i]);
      end
    end
  endtask

  task automatic test_raw_write;
    int slotHits = 0;
    stepCycle(1'b1, 1'b0, 2'd0, 8'h00);
    bus.rd_sel = 2'd2;
    stepCycle(1'b0, 1'b1, 2'd2, 8'hA4);
    total++;
    if (bus.rd_data !== storedOf(8'hA4)) begin
      bad++; $display("[TB] FAIL write_rd_data: got %h expected %h", bus.rd_data, storedOf(8'hA4));
    end
    total++;
    if (bus.ex_ack !== 1'b1) begin
      bad++; $display("[TB] FAIL write_ack_high: got %b expected 1", bus.ex_ack);
    end
    idle(1);
    total++;
    if (bus.ex_ack !== 1'b0) begin
      bad++; $display("[TB] FAIL write_ack_low: got %b expected 0", bus.ex_ack);
    end
    for (int i = 0; i < 16; i++) begin
      idle(1);
      if (bus.an === 4'hB) begin
        slotHits++;
        total++;
        if (bus.seg !== storedOf(8'hA4)) begin
          bad++; $display("[TB] FAIL digit2_seg: got %h expected %h", bus.seg, storedOf(8'hA4));
        end
      end
    end
    total++;
    if (slotHits !== 3) begin
      bad++; $display("[TB] FAIL digit2_slot_count: got %0d expected 3", slotHits);
    end
  endtask

  task automatic test_back_to_back;
    stepCycle(1'b1, 1'b0, 2'd0, 8'h00);
    idle(4);
    bus.rd_sel = 2'd1;
    stepCycle(1'b0, 1'b1, 2'd1, 8'h11);
    total++;
    if (bus.ex_ack !== 1'b1) begin
      bad++; $display("[TB] FAIL b2b_ack_first: got %b expected 1", bus.ex_ack);
    end
    stepCycle(1'b0, 1'b1, 2'd1, 8'h22);
    total++;
    if (bus.ex_ack !== 1'b1 || bus.an !== 4'hD || bus.seg !== storedOf(8'h11)) begin
      bad++;
      $display("[TB] FAIL b2b_first_value: got ack=%b an=%h seg=%h expected ack=1 an=d seg=%h",
               bus.ex_ack, bus.an, bus.seg, storedOf(8'h11));
    end
    idle(1);
    total++;
    if (bus.ex_ack !== 1'b0 || bus.an !== 4'hD || bus.seg !== storedOf(8'h22)) begin
      bad++;
      $display("[TB] FAIL b2b_second_value: got ack=%b an=%h seg=%h expected ack=0 an=d seg=%h",
               bus.ex_ack, bus.an, bus.seg, storedOf(8'h22));
    end
    total++;
    if (bus.rd_data !== storedOf(8'h22)) begin
      bad++; $display("[TB] FAIL b2b_rd_data: got %h expected %h", bus.rd_data, storedOf(8'h22));
    end
  endtask

  task automatic test_reset_with_write;
    stepCycle(1'b1, 1'b0, 2'd0, 8'h00);
    idle(2);
    bus.rd_sel = 2'd0;
    stepCycle(1'b1, 1'b1, 2'd0, 8'h55);
    total++;
    if (bus.rd_data !== 8'hFF) begin
      bad++; $display("[TB] FAIL rst_write_dig: got %h expected ff", bus.rd_data);
    end
    idle(1);
    total++;
    if (bus.ex_ack !== 1'b0 || bus.rd_data !== 8'hFF) begin
      bad++;
      $display("[TB] FAIL rst_write_ack: got ack=%b dig=%h expected ack=0 dig=ff",
               bus.ex_ack, bus.rd_data);
    end
  endtask

  task automatic test_decode;
`ifdef HEX_DECODE_EN
    logic [7:0] exp0 = 8'h08;
    logic [7:0] exp3 = 8'h8E;
`else
    logic [7:0] exp0 = 8'h1A;
    logic [7:0] exp3 = 8'h0F;
`endif
    stepCycle(1'b1, 1'b0, 2'd0, 8'h00);
    bus.rd_sel = 2'd0;
    stepCycle(1'b0, 1'b1, 2'd0, 8'h1A);
    total++;
    if (bus.rd_data !== exp0) begin
      bad++; $display("[TB] FAIL decode_idx0: got %h expected %h", bus.rd_data, exp0);
    end
    bus.rd_sel = 2'd3;
    stepCycle(1'b0, 1'b1, 2'd3, 8'h0F);
    total++;
    if (bus.rd_data !== exp3) begin
      bad++; $display("[TB] FAIL decode_idx3: got %h expected %h", bus.rd_data, exp3);
    end
    idle(16);
  endtask

  // Scenario sequence followed by the summary line
  initial begin
    reset        = 1'b1;
    bus.ex_write = 1'b0;
    bus.ex_ano   = 2'd0;
    bus.ex_data  = 32'h0;
    bus.rd_sel   = 2'd0;
    test_reset();
    test_scan_order();
    test_raw_write();
    test_back_to_back();
    test_reset_with_write();
    test_decode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
